// File: rtl/hash_pkg.sv
// Shared types and constants for the hashing core and its memory responder.
package hash_pkg;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 16;
  localparam logic [WORD_W-1:0] BAD_DATA_DEF = 32'hDEADBEEF;
  localparam int NUM_WORDS = 20;
  localparam int NUM_NONCES = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    RUN,
    COMPLETE
  } seq_state_t;
endpackage

// File: rtl/resp_sram.sv
// Word SRAM model: one muxed write port, registered core and host reads.
module resp_sram
  import hash_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IW = 10,
  parameter logic [WORD_W-1:0] BAD_DATA = BAD_DATA_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              host_sel,
  input  logic              host_we,
  input  logic              host_re,
  input  logic              host_ok,
  input  logic [IW-1:0]     host_idx,
  input  logic [WORD_W-1:0] host_wdata,
  input  logic              core_we,
  input  logic              core_ok,
  input  logic [IW-1:0]     core_idx,
  input  logic [WORD_W-1:0] core_wdata,
  output logic [WORD_W-1:0] core_rdata,
  output logic [WORD_W-1:0] host_rdata
);
  logic [WORD_W-1:0] mem [DEPTH];
  logic              we;
  logic [IW-1:0]     widx;
  logic [WORD_W-1:0] wdata;

  always_comb begin
    we    = host_sel ? (host_we && host_ok) : (core_we && core_ok);
    widx  = host_sel ? host_idx : core_idx;
    wdata = host_sel ? host_wdata : core_wdata;
  end

  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

  // Reads sample the array before this edge's write lands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_rdata <= '0;
      host_rdata <= '0;
    end else begin
      core_rdata <= core_ok ? mem[core_idx] : BAD_DATA;
      if (host_re)
        host_rdata <= host_ok ? mem[host_idx] : BAD_DATA;
    end
  end
endmodule

// File: rtl/hash_mem_responder.sv
// Memory responder for the hashing core: SRAM, host port, run sequencer.
module hash_mem_responder
  import hash_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter logic [ADDR_W-1:0] BASE = 16'h0000,
  parameter int TIMEOUT = 20000,
  parameter logic [WORD_W-1:0] BAD_DATA = BAD_DATA_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_write_data,
  output logic [WORD_W-1:0] mem_read_data,
  input  logic              core_done,
  output logic              core_start,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [WORD_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [WORD_W-1:0] host_rdata,
  input  logic              go,
  output logic              run_done,
  output logic              timeout,
  output logic              addr_err,
  output logic [7:0]        wr_count
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 5);
  localparam logic [ADDR_W:0] LIM = (ADDR_W + 1)'(DEPTH);

  seq_state_t      state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            set_to;
  logic            active, go_ok;
  logic [ADDR_W:0] core_off, host_off;
  logic            core_ok, host_ok;
  logic            core_wr, core_commit, err_now;

  always_comb begin
    core_off = {1'b0, mem_addr} - {1'b0, BASE};
    host_off = {1'b0, host_addr} - {1'b0, BASE};
    core_ok  = (mem_addr >= BASE) && (core_off < LIM);
    host_ok  = (host_addr >= BASE) && (host_off < LIM);
    active   = (state != IDLE);
    go_ok    = go && !active;
    host_gnt = host_req && !active;
    core_wr  = mem_we && active;
    core_commit = core_wr && core_ok;
    err_now  = (host_gnt && !host_ok) || (active && !core_ok);
  end

  resp_sram #(
    .DEPTH(DEPTH),
    .IW(IW),
    .BAD_DATA(BAD_DATA)
  ) u_sram (
    .clk(clk),
    .reset_n(reset_n),
    .host_sel(host_gnt),
    .host_we(host_we),
    .host_re(host_gnt && !host_we),
    .host_ok(host_ok),
    .host_idx(host_off[IW-1:0]),
    .host_wdata(host_wdata),
    .core_we(core_wr),
    .core_ok(core_ok),
    .core_idx(core_off[IW-1:0]),
    .core_wdata(mem_write_data),
    .core_rdata(mem_read_data),
    .host_rdata(host_rdata)
  );

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    core_start = 1'b0;
    run_done   = 1'b0;
    set_to     = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (go) state_nx = START;
      end
      START: begin
        core_start = 1'b1;
        cnt_nx     = cnt + CW'(1);
        state_nx   = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        cnt_nx = cnt + CW'(1);
        if (cnt >= CW'(TIMEOUT)) begin
          set_to   = 1'b1;
          state_nx = COMPLETE;
        end else if (!core_done) begin
          state_nx = RUN;
        end else if (cnt >= CW'(4)) begin
          // Core never went busy: it finished instantly.
          state_nx = COMPLETE;
        end
      end
      RUN: begin
        cnt_nx = cnt + CW'(1);
        if (cnt >= CW'(TIMEOUT)) begin
          set_to   = 1'b1;
          state_nx = COMPLETE;
        end else if (core_done) begin
          state_nx = COMPLETE;
        end
      end
      COMPLETE: begin
        run_done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      host_rvalid <= 1'b0;
      timeout     <= 1'b0;
      addr_err    <= 1'b0;
      wr_count    <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      host_rvalid <= host_gnt && !host_we;
      if (go_ok) begin
        wr_count <= '0;
        addr_err <= 1'b0;
        timeout  <= 1'b0;
      end else begin
        if (core_commit && wr_count != 8'hFF)
          wr_count <= wr_count + 8'd1;
        if (set_to) timeout <= 1'b1;
      end
      if (err_now) addr_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_hash_mem_responder.sv
// Bench for hash_mem_responder: per-cycle reference model plus directed runs.
module tb_hash_mem_responder;
  import hash_pkg::*;

  localparam int DEPTH = 1024;
  localparam logic [15:0] BASE = 16'h1000;
  localparam int TMO = 100;
  localparam logic [31:0] BAD = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        core_done;
  logic        core_start;
  logic        host_req;
  logic        host_we;
  logic [15:0] host_addr;
  logic [31:0] host_wdata;
  logic        host_gnt;
  logic        host_rvalid;
  logic [31:0] host_rdata;
  logic        go;
  logic        run_done;
  logic        timeout;
  logic        addr_err;
  logic [7:0]  wr_count;

  always #5 clk = ~clk;

  hash_mem_responder #(
    .DEPTH(DEPTH),
    .BASE(BASE),
    .TIMEOUT(TMO),
    .BAD_DATA(BAD)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data),
    .core_done(core_done),
    .core_start(core_start),
    .host_req(host_req),
    .host_we(host_we),
    .host_addr(host_addr),
    .host_wdata(host_wdata),
    .host_gnt(host_gnt),
    .host_rvalid(host_rvalid),
    .host_rdata(host_rdata),
    .go(go),
    .run_done(run_done),
    .timeout(timeout),
    .addr_err(addr_err),
    .wr_count(wr_count)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory image plus run progress in cycles since START.
  logic [31:0] mm [DEPTH];
  bit          kn [DEPTH];
  int          age;
  bit          cpl, busy, m_to, m_err, m_rv, mrd_kn;
  logic [31:0] m_mrd, m_hrd;
  int          m_wr;

  function automatic bit inr(input logic [15:0] a);
    return int'(a) >= int'(BASE) && int'(a) < int'(BASE) + DEPTH;
  endfunction

  function automatic int idx(input logic [15:0] a);
    return int'(a) - int'(BASE);
  endfunction

  task automatic model_reset;
    age = -1; cpl = 0; busy = 0; m_to = 0; m_err = 0;
    m_rv = 0; m_mrd = '0; mrd_kn = 1; m_hrd = '0; m_wr = 0;
  endtask

  task automatic model_step;
    bit idle, gnt, ending;
    idle = age < 0 && !cpl;
    gnt = host_req && idle;
    if (inr(mem_addr)) begin
      m_mrd = mm[idx(mem_addr)];
      mrd_kn = kn[idx(mem_addr)];
    end else begin
      m_mrd = BAD;
      mrd_kn = 1;
    end
    m_rv = gnt && !host_we;
    if (m_rv) m_hrd = inr(host_addr) ? mm[idx(host_addr)] : BAD;
    if (idle && go) begin
      m_err = 0; m_to = 0; m_wr = 0;
    end
    if ((gnt && !inr(host_addr)) || (!idle && !inr(mem_addr)))
      m_err = 1;
    if (gnt && host_we && inr(host_addr)) begin
      mm[idx(host_addr)] = host_wdata;
      kn[idx(host_addr)] = 1;
    end
    if (!idle && mem_we && inr(mem_addr)) begin
      mm[idx(mem_addr)] = mem_write_data;
      kn[idx(mem_addr)] = 1;
      if (m_wr < 255) m_wr++;
    end
    if (cpl) begin
      cpl = 0;
    end else if (age < 0) begin
      if (go) begin age = 0; busy = 0; end
    end else if (age == 0) begin
      age = 1;
    end else begin
      ending = 0;
      if (age >= TMO) begin m_to = 1; ending = 1; end
      else if (!core_done) busy = 1;
      else if (busy || age >= 4) ending = 1;
      if (ending) begin cpl = 1; age = -1; end
      else age++;
    end
  endtask

  task automatic compare;
    if (!reset_n) model_reset;
    chk("core_start", 32'(core_start), 32'(age == 0));
    chk("run_done", 32'(run_done), 32'(cpl));
    chk("host_gnt", 32'(host_gnt), 32'(host_req && age < 0 && !cpl));
    chk("timeout", 32'(timeout), 32'(m_to));
    chk("addr_err", 32'(addr_err), 32'(m_err));
    chk("wr_count", 32'(wr_count), m_wr);
    chk("host_rvalid", 32'(host_rvalid), 32'(m_rv));
    if (m_rv) chk("host_rdata", host_rdata, m_hrd);
    if (mrd_kn) chk("mem_read_data", mem_read_data, m_mrd);
  endtask

  initial begin
    model_reset;
    forever begin
      @(posedge clk);
      if (reset_n) model_step;
      @(negedge clk);
      compare;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [15:0] a, input logic [31:0] d);
    host_req = 1; host_we = 1; host_addr = a; host_wdata = d;
    #1;
    chk("hw_gnt", 32'(host_gnt), 32'd1);
    tick;
    host_req = 0; host_we = 0;
  endtask

  task automatic host_read(input string nm, input logic [15:0] a,
                           input logic [31:0] exp);
    host_req = 1; host_we = 0; host_addr = a;
    #1;
    chk({nm, "_gnt"}, 32'(host_gnt), 32'd1);
    tick;
    host_req = 0;
    chk({nm, "_rvalid"}, 32'(host_rvalid), 32'd1);
    chk(nm, host_rdata, exp);
    tick;
    chk({nm, "_rvalid_drop"}, 32'(host_rvalid), 32'd0);
  endtask

  task automatic go_start;
    go = 1;
    tick;
    go = 0;
    chk("go_core_start", 32'(core_start), 32'd1);
  endtask

  task automatic wait_run_done(input int max, output int n);
    n = 0;
    while (run_done !== 1'b1 && n < max) begin
      tick;
      n++;
    end
    chk("run_done_seen", 32'(run_done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset_n = 0; mem_we = 0; mem_addr = BASE; mem_write_data = '0;
    core_done = 1; host_req = 0; host_we = 0; host_addr = BASE;
    host_wdata = '0; go = 0;
    repeat (3) tick;
    chk("rst_mem_read_data", mem_read_data, 32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
    chk("rst_host_rvalid", 32'(host_rvalid), 32'd0);
    reset_n = 1;
    tick;

    // Preload and read back the message block.
    for (int i = 0; i < 20; i++) host_write(BASE + 16'(i), 32'(i + 1));
    for (int i = 0; i < 20; i++) host_read("msg_rd", BASE + 16'(i), 32'(i + 1));
    host_read("msg_rd_last", BASE + 16'd19, 32'h14);

    // Normal run: busy two cycles after start, 20 reads, 16 writes.
    go_start;
    tick;
    chk("start_one_pulse", 32'(core_start), 32'd0);
    tick;
    core_done = 0;
    for (int i = 0; i < 20; i++) begin
      mem_addr = BASE + 16'(i);
      tick;
      chk("core_rd", mem_read_data, 32'(i + 1));
    end
    for (int j = 0; j < 16; j++) begin
      mem_we = 1;
      mem_addr = BASE + 16'h100 + 16'(j);
      mem_write_data = 32'hA5A50000 + 32'(j);
      core_done = (j == 15);
      tick;
    end
    mem_we = 0; mem_addr = BASE;
    chk("run_done_pulse", 32'(run_done), 32'd1);
    chk("wr_count_16", 32'(wr_count), 32'd16);
    tick;
    chk("run_done_one", 32'(run_done), 32'd0);
    for (int j = 0; j < 16; j++)
      host_read("res_rd", BASE + 16'h100 + 16'(j), 32'hA5A50000 + 32'(j));

    // Out-of-range host read, idle core write ignored.
    host_read("oor_rd", BASE + 16'(DEPTH), 32'hDEADBEEF);
    chk("oor_addr_err", 32'(addr_err), 32'd1);
    host_write(BASE + 16'h200, 32'h55);
    mem_we = 1; mem_addr = BASE + 16'h200; mem_write_data = 32'h66;
    tick;
    mem_we = 0; mem_addr = BASE;
    chk("idle_wr_cnt", 32'(wr_count), 32'd16);
    host_read("idle_wr_rd", BASE + 16'h200, 32'h55);

    // Out-of-range core write during a run.
    go_start;
    chk("go_clr_err", 32'(addr_err), 32'd0);
    tick;
    core_done = 0;
    tick;
    mem_we = 1; mem_addr = BASE + 16'(DEPTH) + 16'd5;
    mem_write_data = 32'h77;
    tick;
    mem_we = 0; mem_addr = BASE;
    chk("core_oor_err", 32'(addr_err), 32'd1);
    chk("core_oor_cnt", 32'(wr_count), 32'd0);
    core_done = 1;
    tick;
    chk("oor_run_done", 32'(run_done), 32'd1);
    tick;

    // Timeout run with a host write held throughout.
    go_start;
    chk("go_clr_err2", 32'(addr_err), 32'd0);
    host_req = 1; host_we = 1;
    host_addr = BASE + 16'h300; host_wdata = 32'h12345678;
    tick;
    tick;
    core_done = 0;
    wait_run_done(200, n);
    chk("timeout_latency", 32'(n + 2), 32'd101);
    chk("timeout_flag", 32'(timeout), 32'd1);
    chk("held_gnt_cpl", 32'(host_gnt), 32'd0);
    core_done = 1;
    tick;
    chk("held_gnt_idle", 32'(host_gnt), 32'd1);
    tick;
    host_req = 0; host_we = 0;
    host_read("held_wr_rd", BASE + 16'h300, 32'h12345678);

    // go together with a host write; core finishes instantly.
    go = 1; host_req = 1; host_we = 1;
    host_addr = BASE + 16'h301; host_wdata = 32'h0BADF00D;
    #1;
    chk("go_host_gnt", 32'(host_gnt), 32'd1);
    tick;
    go = 0; host_req = 0; host_we = 0;
    chk("go_host_start", 32'(core_start), 32'd1);
    chk("go_clr_to", 32'(timeout), 32'd0);
    wait_run_done(20, n);
    chk("instant_latency", 32'(n), 32'd5);
    tick;
    host_read("go_host_rd", BASE + 16'h301, 32'h0BADF00D);

    // Same-address read and write in one cycle.
    go_start;
    tick;
    core_done = 0;
    tick;
    mem_addr = BASE + 16'h100; mem_we = 1;
    mem_write_data = 32'hCAFE0001;
    tick;
    mem_we = 0;
    chk("rbw_old", mem_read_data, 32'hA5A50000);
    tick;
    chk("rbw_new", mem_read_data, 32'hCAFE0001);
    core_done = 1; mem_addr = BASE;
    tick;
    chk("rbw_cnt", 32'(wr_count), 32'd1);
    tick;

    // Reset mid-run keeps SRAM contents.
    go_start;
    tick;
    reset_n = 0;
    #1;
    chk("mid_rst_cnt", 32'(wr_count), 32'd0);
    chk("mid_rst_start", 32'(core_start), 32'd0);
    tick;
    reset_n = 1;
    tick;
    host_read("mid_rst_rd", BASE + 16'h100, 32'hCAFE0001);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hash_mem_responder.md
Name: hash_mem_responder

Overview:
- Memory-side responder for the hashing core's single-port memory interface (mem_we, mem_addr, mem_write_data, mem_read_data).
- Holds message and result words in an internal word-addressed SRAM model.
- Gives the host a preload/readback port and a run sequencer that pulses the core's start and reports completion.
- Sits between the testbench/host and the hashing core at the top level. The core's mem_clk is tied to clk outside this block.

Parameters:
- DEPTH, 1024, number of 32-bit words stored.
- BASE, 16'h0000, address of word 0; valid range is BASE..BASE+DEPTH-1.
- TIMEOUT, 20000, maximum cycles from start pulse to core completion before the run is aborted.
- BAD_DATA, 32'hDEADBEEF, read value returned for out-of-range addresses.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset.
- mem_we  in  1  core write enable.
- mem_addr  in  16  core word address.
- mem_write_data  in  32  core write data.
- mem_read_data  out  32  registered read data to core.
- core_done  in  1  core done (high when core idle).
- core_start  out  1  one-cycle start pulse to core.
- host_req  in  1  host access request.
- host_we  in  1  host write (1) / read (0).
- host_addr  in  16  host word address.
- host_wdata  in  32  host write data.
- host_gnt  out  1  host access accepted this cycle.
- host_rvalid  out  1  host read data valid.
- host_rdata  out  32  host read data.
- go  in  1  host request to launch a run.
- run_done  out  1  one-cycle pulse: run finished.
- timeout  out  1  sticky: last run aborted by timeout.
- addr_err  out  1  sticky: out-of-range access since last go.
- wr_count  out  8  core writes accepted in current/last run.

Behaviour:
- Reset is asynchronous and active-low on reset_n; clock is clk. All outputs reset to 0. Sequencer resets to IDLE. SRAM contents are not reset.
- Read latency is 1 cycle. mem_read_data updates at every posedge to mem[mem_addr-BASE], independent of mem_we; read-before-write on the same address returns the old word.
- Core writes occur at the posedge when mem_we=1 and the sequencer is not IDLE. Core writes in IDLE are ignored and do not count.
- Out-of-range rule, for the core or the host: reads return BAD_DATA, writes are dropped, addr_err is set. addr_err and timeout clear on an accepted go.
- Host arbitration: host_gnt = host_req and sequencer in IDLE, combinational. The host is never granted during a run; host_req held during a run is granted when the sequencer returns to IDLE.
- A granted host write commits at that posedge.
- A granted host read: host_rdata is valid with host_rvalid=1 on the following cycle for exactly 1 cycle.
- Sequencer states:
  - IDLE: on go=1, clear wr_count, addr_err and timeout, then go to START. go in any other state is ignored.
  - START: core_start=1 for exactly this cycle, then go to WAIT_BUSY. The cycle counter starts at 0 here.
  - WAIT_BUSY: wait for core_done=0, then go to RUN. If core_done stays 1 for 4 cycles, treat the core as having finished instantly and go to COMPLETE.
  - RUN: count each core write (wr_count saturates at 255). On core_done=1, go to COMPLETE.
  - COMPLETE: run_done=1 for one cycle, then go to IDLE.
  - Timeout: in WAIT_BUSY or RUN, when the cycle counter reaches TIMEOUT, set timeout and go to COMPLETE.
- Simultaneous core_done=1 and mem_we=1 in RUN: the write commits and is counted.
- Simultaneous go and host_req in IDLE: the host access is granted and commits that cycle, and the sequencer moves to START.
- Reset mid-run: the sequencer returns to IDLE and SRAM keeps its contents.

Decomposition:
- Shared package hash_pkg holds:
  - seq_state_t enum {IDLE, START, WAIT_BUSY, RUN, COMPLETE}.
  - WORD_W=32 and ADDR_W=16.
  - BAD_DATA default.
  - The message/output word counts (NUM_WORDS=20, NUM_NONCES=16), reused by the core.
- One sub-module: resp_sram (single-port SRAM model with registered read and a mux-selected host/core port).
- Sequencer, arbitration and error logic stay in the top module.

Test Plan:
- Host writes 20 message words 0x01..0x14 to BASE..BASE+19, then reads them back -> each host_rvalid one cycle after gnt, data matches.
- go with a core model that drops done 2 cycles after start, reads 20 words and writes 16 words to BASE+0x100 -> core_start one pulse, wr_count=16, run_done pulse, host readback matches the writes.
- Host read to address BASE+DEPTH -> host_rdata=0xDEADBEEF, addr_err=1. A core write to BASE+DEPTH+5 is dropped and addr_err=1. addr_err clears on the next go.
- Core never reasserts done, TIMEOUT=100 -> run_done 101 cycles after the START cycle, timeout=1.
- host_req held during a run -> host_gnt=0 until the cycle after COMPLETE, then gnt=1 and the write commits.
- Core write and read of the same address in one cycle -> mem_read_data returns the old value next cycle; a subsequent read returns the new value.
